// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected output stage.
// Imported by fc_mac_tree and fc_layer.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fc_state_e;

    localparam int ACC_WIDTH = 32;

    function automatic int fc_beats(input int total, input int ops);
        return (total + ops - 1) / ops;
    endfunction

    // Lanes that still carry real products on the final, partially filled beat.
    function automatic int fc_last_lanes(input int total, input int ops);
        return total - (fc_beats(total, ops) - 1) * ops;
    endfunction

endpackage

// File: rtl/fc_mac_tree.sv
// Combinational beat datapath: per-lane signed multiply, lane masking and a
// pairwise adder tree producing one sign-extended ACC_WIDTH beat sum.
module fc_mac_tree
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int OPS_PER_CYCLE = 10
) (
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] operands,
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] weights,
    input  logic [OPS_PER_CYCLE-1:0]                 lane_mask,
    output logic signed [ACC_WIDTH-1:0]              beat_sum
);

    localparam int LEAVES = 1 << $clog2(OPS_PER_CYCLE);
    localparam int PW     = 2 * DATA_WIDTH;

    // Multiply, mask, then reduce in place level by level (index k reads 2k and 2k+1).
    always_comb begin
        logic signed [ACC_WIDTH-1:0] tree_v [LEAVES];
        logic signed [PW-1:0]        prod_v;
        for (int i = 0; i < LEAVES; i++) begin
            tree_v[i] = {ACC_WIDTH{1'b0}};
        end
        for (int i = 0; i < OPS_PER_CYCLE; i++) begin
            prod_v = $signed(operands[i]) * $signed(weights[i]);
            if (lane_mask[i]) begin
                tree_v[i] = {{(ACC_WIDTH-PW){prod_v[PW-1]}}, prod_v};
            end else begin
                tree_v[i] = {ACC_WIDTH{1'b0}};
            end
        end
        for (int lvl = LEAVES; lvl > 1; lvl = lvl / 2) begin
            for (int k = 0; k < lvl / 2; k++) begin
                tree_v[k] = tree_v[2*k] + tree_v[2*k+1];
            end
        end
        beat_sum = tree_v[0];
    end

endmodule

// File: rtl/fc_layer.sv
// Dense output neuron: accumulates BEATS lane-parallel dot-product beats on top
// of a bias and publishes the 32-bit sum with a one-cycle done_out pulse.
module fc_layer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int OPS_PER_CYCLE  = 10,
    parameter int FC_TOTAL_COUNT = 1024
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] operands,
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] weights,
    input  logic [OPS_PER_CYCLE-1:0][DATA_WIDTH-1:0] biases,
    input  logic                                     start,
    input  logic                                     data_valid,
    output logic signed [ACC_WIDTH-1:0]              result,
    output logic                                     done_out
);

    localparam int BEATS      = fc_beats(FC_TOTAL_COUNT, OPS_PER_CYCLE);
    localparam int LAST_LANES = fc_last_lanes(FC_TOTAL_COUNT, OPS_PER_CYCLE);
    localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [OPS_PER_CYCLE-1:0] FULL_MASK = {OPS_PER_CYCLE{1'b1}};
    localparam logic [OPS_PER_CYCLE-1:0] LAST_MASK = FULL_MASK >> (OPS_PER_CYCLE - LAST_LANES);

    fc_state_e                   state_r, state_s;
    logic [CNT_W-1:0]            beat_cnt_r;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] result_r;
    logic                        done_r;
    logic signed [ACC_WIDTH-1:0] beat_sum_s;
    logic signed [ACC_WIDTH-1:0] bias_ext_s;
    logic [OPS_PER_CYCLE-1:0]    lane_mask_s;
    logic                        last_beat_s;
    logic                        beat_s;

    assign last_beat_s = (beat_cnt_r == CNT_W'(BEATS - 1));
    assign beat_s      = (state_r == ST_ACCUM) && data_valid;
    assign lane_mask_s = last_beat_s ? LAST_MASK : FULL_MASK;
    assign bias_ext_s  = {{(ACC_WIDTH-DATA_WIDTH){biases[0][DATA_WIDTH-1]}}, biases[0]};

    fc_mac_tree #(
        .DATA_WIDTH    (DATA_WIDTH),
        .OPS_PER_CYCLE (OPS_PER_CYCLE)
    ) u_mac_tree (
        .operands  (operands),
        .weights   (weights),
        .lane_mask (lane_mask_s),
        .beat_sum  (beat_sum_s)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ACCUM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (beat_s && last_beat_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_ACCUM;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Accumulator and beat counter; the start cycle seeds the bias and is never a beat.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_r      <= {ACC_WIDTH{1'b0}};
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            acc_r      <= bias_ext_s;
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (beat_s) begin
            acc_r      <= acc_r + beat_sum_s;
            beat_cnt_r <= beat_cnt_r + CNT_W'(1);
        end else begin
            acc_r      <= acc_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Output registers: result captured in DONE and held until the next DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_r <= {ACC_WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else if (state_r == ST_DONE) begin
            result_r <= acc_r;
            done_r   <= 1'b1;
        end else begin
            result_r <= result_r;
            done_r   <= 1'b0;
        end
    end

    assign result   = result_r;
    assign done_out = done_r;

endmodule

// File: tb/tb_fc_layer.sv
// Scoreboard bench for fc_layer: a lane-accurate model pushes each neuron's
// expected sum when its final beat is driven; a monitor pops it on done_out.
module tb_fc_layer;

    localparam int DW      = 8;
    localparam int OPS     = 10;
    localparam int TOTAL   = 1024;
    localparam int N_BEATS = (TOTAL + OPS - 1) / OPS;
    localparam int LAST_N  = TOTAL - (N_BEATS - 1) * OPS;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [OPS-1:0][DW-1:0]     operands;
    logic [OPS-1:0][DW-1:0]     weights;
    logic [OPS-1:0][DW-1:0]     biases;
    logic                       start;
    logic                       data_valid;
    logic signed [31:0]         result;
    logic                       done_out;

    int n_vec = 0;
    int n_err = 0;
    int model_acc;
    int exp_q[$];

    fc_layer #(
        .DATA_WIDTH     (DW),
        .OPS_PER_CYCLE  (OPS),
        .FC_TOTAL_COUNT (TOTAL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .operands   (operands),
        .weights    (weights),
        .biases     (biases),
        .start      (start),
        .data_valid (data_valid),
        .result     (result),
        .done_out   (done_out)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: every done_out pulse must match a pending expectation.
    always @(posedge clock) begin
        #1;
        if (reset === 1'b1 && done_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", {31'd0, done_out}, 32'sd0);
            end else begin
                check_eq("sb_result", result, exp_q.pop_front());
            end
        end
    end

    task automatic begin_run(input logic [7:0] bias, input bit dv_with_start);
        for (int i = 1; i < OPS; i++) biases[i] = 8'($urandom);
        biases[0]  = bias;
        operands   = {OPS{8'h01}};
        weights    = {OPS{8'h01}};
        start      = 1'b1;
        data_valid = dv_with_start;
        model_acc  = int'($signed(bias));
        step();
        start      = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic drive_beat(input logic [OPS-1:0][DW-1:0] ops, input logic [OPS-1:0][DW-1:0] wts,
                              input int idx, input bit start_too);
        int lanes;
        lanes      = (idx == N_BEATS - 1) ? LAST_N : OPS;
        operands   = ops;
        weights    = wts;
        data_valid = 1'b1;
        start      = start_too;
        for (int i = 0; i < lanes; i++)
            model_acc += int'($signed(ops[i])) * int'($signed(wts[i]));
        if (idx == N_BEATS - 1) exp_q.push_back(model_acc);
        step();
        data_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic run_neuron(input logic [7:0] bias, input logic [7:0] op_v, input logic [7:0] w_v,
                              input int gap, input bit hi_last, input int start_at,
                              input bit rnd, input bit dv_start);
        logic [OPS-1:0][DW-1:0] ops;
        logic [OPS-1:0][DW-1:0] wts;
        int                     exp_now;
        begin_run(bias, dv_start);
        for (int b = 0; b < N_BEATS; b++) begin
            for (int i = 0; i < OPS; i++) begin
                ops[i] = rnd ? 8'($urandom) : op_v;
                wts[i] = rnd ? 8'($urandom) : w_v;
                if (hi_last && b == N_BEATS - 1 && i >= LAST_N) begin
                    ops[i] = 8'h7F;
                    wts[i] = 8'h7F;
                end
            end
            if (b == N_BEATS - 1) check_eq("no_early_done", {31'd0, done_out}, 32'sd0);
            drive_beat(ops, wts, b, b == start_at);
            if (b < N_BEATS - 1) begin
                for (int g = 0; g < gap; g++) begin
                    for (int i = 0; i < OPS; i++) begin
                        operands[i] = 8'($urandom);
                        weights[i]  = 8'($urandom);
                    end
                    step();
                end
            end
        end
        exp_now = model_acc;
        check_eq("done_at_last_edge", {31'd0, done_out}, 32'sd0);
        step();
        check_eq("done_pulse", {31'd0, done_out}, 32'sd1);
        check_eq("result_at_done", result, exp_now);
        step();
        check_eq("done_width", {31'd0, done_out}, 32'sd0);
        check_eq("result_hold", result, exp_now);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        data_valid = 1'b0;
        operands   = '0;
        weights    = '0;
        biases     = '0;
        step();
        step();
        check_eq("reset_result", result, 32'sd0);
        check_eq("reset_done", {31'd0, done_out}, 32'sd0);
        reset = 1'b1;
        step();

        // Ones, back-to-back beats.
        run_neuron(8'd5, 8'd1, 8'd1, 0, 1'b0, -1, 1'b0, 1'b0);
        check_eq("s1_value", result, 32'sd1029);
        step();
        step();
        check_eq("s1_idle_hold", result, 32'sd1029);

        // Negative weights with long gaps between beats.
        run_neuron(8'hFF, 8'd2, 8'hFD, 9, 1'b0, -1, 1'b0, 1'b0);
        check_eq("s2_value", result, -32'sd6145);

        // Final-beat masked lanes carry large values.
        run_neuron(8'd5, 8'd1, 8'd1, 0, 1'b1, -1, 1'b0, 1'b0);
        check_eq("s3_value", result, 32'sd1029);

        // Stray start mid-accumulation, then a fresh neuron straight after.
        run_neuron(8'd5, 8'd1, 8'd1, 0, 1'b0, 50, 1'b0, 1'b0);
        check_eq("s4_value", result, 32'sd1029);
        run_neuron(8'h80, 8'd1, 8'd1, 0, 1'b0, -1, 1'b0, 1'b0);
        check_eq("s4_fresh", result, 32'sd896);

        // Reset in the middle of an accumulation.
        begin_run(8'd5, 1'b0);
        for (int b = 0; b < 60; b++) drive_beat({OPS{8'h01}}, {OPS{8'h01}}, b, 1'b0);
        reset = 1'b0;
        #2;
        check_eq("midrst_result", result, 32'sd0);
        check_eq("midrst_done", {31'd0, done_out}, 32'sd0);
        step();
        step();
        reset = 1'b1;
        step();
        run_neuron(8'd5, 8'd1, 8'd1, 0, 1'b0, -1, 1'b0, 1'b0);
        check_eq("s5_value", result, 32'sd1029);

        // data_valid together with start must not count as a beat.
        run_neuron(8'd5, 8'd1, 8'd1, 0, 1'b0, -1, 1'b0, 1'b1);
        check_eq("s6_value", result, 32'sd1029);

        // Random lanes and biases, checked against the model only.
        run_neuron(8'($urandom), 8'd0, 8'd0, 0, 1'b0, -1, 1'b1, 1'b0);
        run_neuron(8'($urandom), 8'd0, 8'd0, 2, 1'b1, -1, 1'b1, 1'b0);

        step();
        check_eq("sb_drained", exp_q.size(), 32'sd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
